uart_tx_fifo: RTL

Byte FIFO and feeder sitting directly upstream of the serial transmitter. Producers push bytes at system-clock rate. The block drains them one at a time into the transmitter using its start/data/ready handshake, so software or other logic never has to poll transmitter ready. One byte is in flight at a time; the order of bytes is preserved.

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-producer / transmitter bundle for uart_tx_fifo.
// master: the environment (byte producers and the serial transmitter).
// slave : the FIFO/feeder block itself.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                idle;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic                ovf_clr;
  logic                overflow;

  modport master (
    output wr_en, wr_data, tx_ready, ovf_clr,
    input  full, empty, level, idle, tx_start, tx_data, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_ready, ovf_clr,
    output full, empty, level, idle, tx_start, tx_data, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus feeder that drains into a serial transmitter
// through a start/data/ready handshake, one byte in flight at a time.
// Optional feature macro: UART_TX_FIFO_OVF_EN enables the sticky overflow
// flag (set on a push while full, cleared by ovf_clr, set wins). Without it
// overflow is tied low and ovf_clr is ignored.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic             full_reg;
  logic             empty_reg;
  state_t           state;
  logic             tx_start_reg;
  logic [7:0]       tx_data_reg;
  logic             push;
  logic             pop;

  // Fullness is judged on the registered flag, so a push on a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign push = bus.wr_en && !full_reg;
  // A byte leaves the FIFO only at the launch edge out of IDLE.
  assign pop  = (state == IDLE) && !empty_reg && bus.tx_ready;

  // Storage array: written on push, no reset so it can map to block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Circular pointers, wrapping naturally at the array depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Next occupancy: +1 on push only, -1 on pop only, unchanged on both.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // Registered occupancy and flags, all derived from the same next value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      level_reg <= level_next;
      full_reg  <= (level_next == LVL_FULL);
      empty_reg <= (level_next == '0);
    end
  end

  // Feeder FSM: launch a byte, then wait for the transmitter to go busy and
  // come back ready before the next launch. tx_data holds between launches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_start_reg <= 1'b1;
            tx_data_reg  <= mem[rd_ptr];
            state        <= SEND;
          end
        end
        SEND: begin
          tx_start_reg <= 1'b0;
          state        <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.tx_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_ready) state <= IDLE;
        end
        default: begin
          tx_start_reg <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic overflow_reg;

  // Sticky overflow: a dropped push sets it, ovf_clr clears it, set wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_reg <= 1'b0;
    end else if (bus.wr_en && full_reg) begin
      overflow_reg <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign bus.overflow = overflow_reg;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = bus.ovf_clr;
  assign bus.overflow   = 1'b0;
`endif

  assign bus.full     = full_reg;
  assign bus.empty    = empty_reg;
  assign bus.level    = level_reg;
  assign bus.tx_start = tx_start_reg;
  assign bus.tx_data  = tx_data_reg;
  // Nothing queued, nothing in flight, transmitter ready.
  assign bus.idle     = empty_reg && (state == IDLE) && bus.tx_ready;

endmodule
